// File: rtl/imem_loader.sv
// Instruction-ROM loader: writes a valid/ready byte stream to ROM from address 0 and pads it to a
// word boundary. The pipeline is held until the image is complete. Optional macro IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  pipe_hold,
    output logic                  done,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   byte_count,
    output logic [7:0]            checksum
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PAD  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = '0;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   CNT_ZERO  = '0;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                  state_r,      state_s;
    logic [ADDR_WIDTH-1:0]   addr_r,       addr_s;
    logic                    mem_we_r,     mem_we_s;
    logic [ADDR_WIDTH-1:0]   mem_addr_r,   mem_addr_s;
    logic [7:0]              mem_wdata_r,  mem_wdata_s;
    logic [ADDR_WIDTH:0]     byte_count_r, byte_count_s;
    logic                    overflow_r,   overflow_s;
    logic                    done_r,       done_s;
    logic                    pipe_hold_r;
    logic                    sum_clr_s;

    // Next-state and datapath decode; every register value is produced here first.
    always_comb begin
        state_s      = state_r;
        addr_s       = addr_r;
        mem_we_s     = 1'b0;
        mem_addr_s   = mem_addr_r;
        mem_wdata_s  = mem_wdata_r;
        byte_count_s = byte_count_r;
        overflow_s   = overflow_r;
        done_s       = done_r;
        sum_clr_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s      = ST_LOAD;
                    addr_s       = ADDR_ZERO;
                    byte_count_s = CNT_ZERO;
                    overflow_s   = 1'b0;
                    done_s       = 1'b0;
                    sum_clr_s    = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    mem_we_s     = 1'b1;
                    mem_addr_s   = addr_r;
                    mem_wdata_s  = in_data;
                    addr_s       = addr_r + ADDR_ONE;
                    byte_count_s = byte_count_r + CNT_ONE;
                    // Word-aligned last byte or a full ROM finishes without padding.
                    if (in_last && (addr_r[1:0] == 2'b11)) begin
                        state_s = ST_DONE;
                    end else if (in_last) begin
                        state_s = ST_PAD;
                    end else if (addr_r == ADDR_LAST) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_LOAD;
                    end
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_PAD: begin
                mem_we_s     = 1'b1;
                mem_addr_s   = addr_r;
                mem_wdata_s  = 8'h00;
                addr_s       = addr_r + ADDR_ONE;
                byte_count_s = byte_count_r + CNT_ONE;
                if (addr_r[1:0] == 2'b11) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_PAD;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_s      = ST_LOAD;
                    addr_s       = ADDR_ZERO;
                    byte_count_s = CNT_ZERO;
                    overflow_s   = 1'b0;
                    done_s       = 1'b0;
                    sum_clr_s    = 1'b1;
                end else begin
                    // done rises one cycle after entry, i.e. after the final write strobe.
                    done_s = 1'b1;
                    if (in_valid) begin
                        overflow_s = 1'b1;
                    end else begin
                        overflow_s = overflow_r;
                    end
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            addr_r       <= ADDR_ZERO;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= ADDR_ZERO;
            mem_wdata_r  <= 8'h00;
            byte_count_r <= CNT_ZERO;
            overflow_r   <= 1'b0;
            done_r       <= 1'b0;
            pipe_hold_r  <= 1'b1;
        end else begin
            state_r      <= state_s;
            addr_r       <= addr_s;
            mem_we_r     <= mem_we_s;
            mem_addr_r   <= mem_addr_s;
            mem_wdata_r  <= mem_wdata_s;
            byte_count_r <= byte_count_s;
            overflow_r   <= overflow_s;
            done_r       <= done_s;
            pipe_hold_r  <= ~done_s;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] checksum_r, checksum_s;

    // Running mod-256 sum of every byte written, pad bytes included.
    always_comb begin
        checksum_s = checksum_r;
        if (sum_clr_s) begin
            checksum_s = 8'h00;
        end else if (mem_we_s) begin
            checksum_s = checksum_r + mem_wdata_s;
        end else begin
            checksum_s = checksum_r;
        end
    end

    // Checksum register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            checksum_r <= 8'h00;
        end else begin
            checksum_r <= checksum_s;
        end
    end

    assign checksum = checksum_r;
`else
    logic unused_sum_clr_s;
    assign unused_sum_clr_s = sum_clr_s;
    assign checksum         = 8'h00;
`endif

    assign in_ready   = (state_r == ST_LOAD);
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign byte_count = byte_count_r;
    assign overflow   = overflow_r;
    assign done       = done_r;
    assign pipe_hold  = pipe_hold_r;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; expected values are hand-derived constants
// and running byte sums computed here.
module tb_imem_loader;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, start, in_valid, in_last;
    logic [7:0] in_data;
    logic       in_ready, mem_we, pipe_hold, done, overflow;
    logic [7:0] mem_addr, mem_wdata, checksum;
    logic [8:0] byte_count;

    imem_loader #(.ADDR_WIDTH(8), .DEPTH(256)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .pipe_hold(pipe_hold), .done(done), .overflow(overflow),
        .byte_count(byte_count), .checksum(checksum)
    );

    always #5 clk = ~clk;

    // Shadow ROM: records every write strobe and how often each address was hit.
    logic [7:0] rom  [256];
    int         hits [256];
    int         wr_cnt;
    logic       mon_clr;
    always @(posedge clk) begin
        if (mon_clr) begin
            for (int a = 0; a < 256; a++) begin
                hits[a] <= 0;
                rom[a]  <= 8'h00;
            end
            wr_cnt <= 0;
        end else if (mem_we) begin
            rom[mem_addr]  <= mem_wdata;
            hits[mem_addr] <= hits[mem_addr] + 1;
            wr_cnt         <= wr_cnt + 1;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        step();
        mon_clr = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    logic [7:0] img1 [8] = '{8'hE2, 8'h11, 8'h00, 8'h00, 8'hE7, 8'hD1, 8'h20, 8'h00};
    logic [7:0] img2 [8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h00, 8'h00};
    logic [7:0] img6 [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    logic [7:0] sum;
    int         bad;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; mon_clr = 1'b0;
        step(); step();
        chk("rst_mem_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_pipe_hold", pipe_hold, 1);
        chk("rst_done", done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_count", byte_count, 0);
        chk("rst_checksum", checksum, 0);
        chk("rst_in_ready", in_ready, 0);
        reset = 1'b1;
        clear_mon();
        chk("idle_in_ready", in_ready, 0);

        // Word-aligned 8-byte image, in_valid held high.
        pulse_start();
        chk("t1_in_ready", in_ready, 1);
        sum = 8'h00;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = img1[i]; in_last = (i == 7);
            step();
            sum = sum + img1[i];
            chk("t1_we", mem_we, 1);
            chk("t1_addr", mem_addr, i);
            chk("t1_wdata", mem_wdata, img1[i]);
        end
        in_valid = 1'b0; in_last = 1'b0;
        chk("t1_done_early", done, 0);
        chk("t1_hold_early", pipe_hold, 1);
        step();
        chk("t1_done", done, 1);
        chk("t1_hold", pipe_hold, 0);
        chk("t1_count", byte_count, 8);
        chk("t1_we_off", mem_we, 0);
        chk("t1_checksum", checksum, CK_EN ? sum : 8'h00);
        chk("t1_writes", wr_cnt, 8);
        bad = 0;
        for (int a = 0; a < 8; a++) if (rom[a] !== img1[a] || hits[a] != 1) bad++;
        chk("t1_rom", bad, 0);

        // 6-byte image padded with two zero bytes.
        clear_mon();
        pulse_start();
        chk("t2_done_clr", done, 0);
        chk("t2_hold_set", pipe_hold, 1);
        sum = 8'h00;
        for (int i = 0; i < 6; i++) begin
            send(img2[i], i == 5);
            sum = sum + img2[i];
        end
        chk("t2_ready_pad", in_ready, 0);
        chk("t2_addr5", mem_addr, 5);
        step();
        chk("t2_pad6_we", mem_we, 1);
        chk("t2_pad6_addr", mem_addr, 6);
        chk("t2_pad6_data", mem_wdata, 0);
        chk("t2_ready_pad6", in_ready, 0);
        step();
        chk("t2_pad7_addr", mem_addr, 7);
        chk("t2_pad7_done", done, 0);
        step();
        chk("t2_done", done, 1);
        chk("t2_we_off", mem_we, 0);
        chk("t2_count", byte_count, 8);
        chk("t2_checksum", checksum, CK_EN ? sum : 8'h00);
        chk("t2_writes", wr_cnt, 8);
        bad = 0;
        for (int a = 0; a < 8; a++) if (rom[a] !== img2[a] || hits[a] != 1) bad++;
        chk("t2_rom", bad, 0);

        // 300-byte stream without in_last: ROM fills, then overflow.
        clear_mon();
        pulse_start();
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'b1; in_data = 8'(i); in_last = 1'b0;
            step();
            if (i == 255) begin
                chk("t3_last_addr", mem_addr, 255);
                chk("t3_ovf_before", overflow, 0);
            end
            if (i == 256) begin
                chk("t3_ovf_first", overflow, 1);
                chk("t3_no_wrap_we", mem_we, 0);
            end
        end
        in_valid = 1'b0;
        step();
        chk("t3_writes", wr_cnt, 256);
        chk("t3_count", byte_count, 256);
        chk("t3_done", done, 1);
        chk("t3_ovf_sticky", overflow, 1);
        bad = 0;
        for (int a = 0; a < 256; a++) if (rom[a] !== 8'(a) || hits[a] != 1) bad++;
        chk("t3_rom", bad, 0);

        // in_valid toggling every other cycle.
        clear_mon();
        pulse_start();
        chk("t4_ovf_clr", overflow, 0);
        for (int i = 0; i < 4; i++) begin
            send(8'h40 + 8'(i), i == 3);
            chk("t4_we_hs", mem_we, 1);
            chk("t4_addr", mem_addr, i);
            step();
            chk("t4_we_gap", mem_we, 0);
        end
        chk("t4_done", done, 1);
        chk("t4_writes", wr_cnt, 4);
        bad = 0;
        for (int a = 0; a < 4; a++) if (rom[a] !== (8'h40 + 8'(a)) || hits[a] != 1) bad++;
        chk("t4_rom", bad, 0);

        // Reset after 3 bytes, then a clean reload.
        clear_mon();
        pulse_start();
        for (int i = 0; i < 3; i++) send(8'h70 + 8'(i), 1'b0);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("t5_done", done, 0);
        chk("t5_hold", pipe_hold, 1);
        chk("t5_count", byte_count, 0);
        chk("t5_idle", in_ready, 0);
        chk("t5_we", mem_we, 0);
        clear_mon();
        pulse_start();
        for (int i = 0; i < 4; i++) send(8'h80 + 8'(i), i == 3);
        step();
        chk("t5_reload_done", done, 1);
        chk("t5_reload_count", byte_count, 4);
        chk("t5_reload_writes", wr_cnt, 4);
        bad = 0;
        for (int a = 0; a < 4; a++) if (rom[a] !== (8'h80 + 8'(a)) || hits[a] != 1) bad++;
        chk("t5_rom", bad, 0);

        // Reload from DONE with AA,BB,CC,DD.
        clear_mon();
        pulse_start();
        chk("t6_done_clr", done, 0);
        chk("t6_hold", pipe_hold, 1);
        chk("t6_ck_clr", checksum, 0);
        for (int i = 0; i < 4; i++) send(img6[i], i == 3);
        chk("t6_hold_last", pipe_hold, 1);
        chk("t6_done_last", done, 0);
        step();
        chk("t6_done", done, 1);
        chk("t6_release", pipe_hold, 0);
        chk("t6_checksum", checksum, CK_EN ? 8'h0E : 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
